alu_arbiter: RTL and testbench

- Shares one 4-bit combinational `alu` instance between two independent requesters.
- Round-robin arbitration with valid/ready handshakes on each request port and on the result port.
- Each granted operation is evaluated by the ALU and captured in a one-entry output register, tagged with the requester id.
- Sits between the two datapath clients and the `alu` block: the only path by which either client reaches the ALU.

---
 rtl/alu_pkg.sv | 27 ++
 rtl/alu.sv | 29 ++
 rtl/alu_arbiter.sv | 91 +++++++++
 tb/tb_alu_arbiter.sv | 329 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings, datapath widths and the result record
// carried by the arbiter's output register.
package alu_pkg;

   localparam int ALU_W   = 4;
   localparam int ALU_OPW = 3;

   localparam logic [ALU_OPW-1:0] OP_AND  = 3'b000;
   localparam logic [ALU_OPW-1:0] OP_OR   = 3'b001;
   localparam logic [ALU_OPW-1:0] OP_ADD  = 3'b010;
   localparam logic [ALU_OPW-1:0] OP_ILL  = 3'b011;
   localparam logic [ALU_OPW-1:0] OP_ANDN = 3'b100;
   localparam logic [ALU_OPW-1:0] OP_ORN  = 3'b101;
   localparam logic [ALU_OPW-1:0] OP_SUB  = 3'b110;
   localparam logic [ALU_OPW-1:0] OP_SLT  = 3'b111;

   typedef struct packed {
      logic             id;
      logic             err;
      logic [ALU_W-1:0] data;
   } alu_res_t;

   function automatic logic op_is_illegal(input logic [ALU_OPW-1:0] op);
      return op == OP_ILL;
   endfunction

endpackage

// File: rtl/alu.sv
// Combinational ALU: op[2] inverts B (and carries in for subtract), op[1:0] picks
// and / or / sum / slt. slt is the sign of A-B, so it is only meaningful without overflow.
module alu
   import alu_pkg::*;
#(
   parameter int W = ALU_W
) (
   input  logic [W-1:0]       a,
   input  logic [W-1:0]       b,
   input  logic [ALU_OPW-1:0] op,
   output logic [W-1:0]       y
);

   logic [W-1:0] b_eff;
   logic [W-1:0] sum;

   always_comb begin
      b_eff = op[2] ? ~b : b;
      sum   = a + b_eff + {{(W-1){1'b0}}, op[2]};
      y     = '0;
      case (op[1:0])
         2'b00:   y = a & b_eff;
         2'b01:   y = a | b_eff;
         2'b10:   y = sum;
         default: y = op[2] ? {{(W-1){1'b0}}, sum[W-1]} : '0;
      endcase
   end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters; the granted result
// lands in a one-entry output register tagged with the requester id.
module alu_arbiter
   import alu_pkg::*;
#(
   parameter int W   = 4,
   parameter int OPW = 3
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           req0_valid,
   input  logic [W-1:0]   req0_a,
   input  logic [W-1:0]   req0_b,
   input  logic [OPW-1:0] req0_op,
   output logic           req0_ready,
   input  logic           req1_valid,
   input  logic [W-1:0]   req1_a,
   input  logic [W-1:0]   req1_b,
   input  logic [OPW-1:0] req1_op,
   output logic           req1_ready,
   output logic           res_valid,
   output logic [W-1:0]   res_data,
   output logic           res_id,
   output logic           res_err,
   input  logic           res_ready
);

   if (W != ALU_W || OPW != ALU_OPW) begin : g_cfg_err
      $error("alu_arbiter: W must be 4 and OPW must be 3 to match the shared alu");
   end

   logic           slot_free;
   logic           gnt0;
   logic           gnt1;
   logic           xfer;
   logic           sel;
   logic           rr_last;
   logic [W-1:0]   alu_a;
   logic [W-1:0]   alu_b;
   logic [OPW-1:0] alu_op;
   logic [W-1:0]   alu_y;
   alu_res_t       res_next;

   // rr_last=1 means requester 1 was served last, so requester 0 wins a tie
   always_comb begin
      slot_free = !res_valid || res_ready;
      gnt0      = rst_n && slot_free && req0_valid && (!req1_valid || rr_last);
      gnt1      = rst_n && slot_free && req1_valid && (!req0_valid || !rr_last);
      xfer      = gnt0 || gnt1;
      sel       = gnt1;
      alu_a     = sel ? req1_a  : req0_a;
      alu_b     = sel ? req1_b  : req0_b;
      alu_op    = sel ? req1_op : req0_op;
   end

   assign req0_ready = gnt0;
   assign req1_ready = gnt1;

   alu u_alu (
      .a  (alu_a),
      .b  (alu_b),
      .op (alu_op),
      .y  (alu_y)
   );

   always_comb begin
      res_next.id   = sel;
      res_next.err  = op_is_illegal(alu_op);
      res_next.data = op_is_illegal(alu_op) ? '0 : alu_y;
   end

   // A grant overwrites the slot even while it drains, so back-to-back ops have no bubble
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         res_valid <= 1'b0;
         res_data  <= '0;
         res_id    <= 1'b0;
         res_err   <= 1'b0;
         rr_last   <= 1'b1;
      end else if (xfer) begin
         res_valid <= 1'b1;
         res_data  <= res_next.data;
         res_id    <= res_next.id;
         res_err   <= res_next.err;
         rr_last   <= res_next.id;
      end else if (res_ready) begin
         res_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenario tasks plus a scoreboard
// that predicts every accepted operation and checks it when the result is consumed.
module tb_alu_arbiter;
   import alu_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req0_valid, req1_valid;
   logic [3:0] req0_a, req0_b, req1_a, req1_b;
   logic [2:0] req0_op, req1_op;
   logic       req0_ready, req1_ready;
   logic       res_valid;
   logic [3:0] res_data;
   logic       res_id;
   logic       res_err;
   logic       res_ready;

   int checks = 0;
   int failures = 0;
   logic [5:0] sb[$];

   always #5 clk = ~clk;

   alu_arbiter #(.W(4), .OPW(3)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req0_valid),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_op    (req0_op),
      .req0_ready (req0_ready),
      .req1_valid (req1_valid),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_op    (req1_op),
      .req1_ready (req1_ready),
      .res_valid  (res_valid),
      .res_data   (res_data),
      .res_id     (res_id),
      .res_err    (res_err),
      .res_ready  (res_ready)
   );

   function automatic logic [4:0] ref_alu(input logic [3:0] a, input logic [3:0] b,
                                          input logic [2:0] op);
      logic [3:0] r;
      logic       e;
      e = 1'b0;
      case (op)
         3'b000:  r = a & b;
         3'b001:  r = a | b;
         3'b010:  r = a + b;
         3'b100:  r = a & ~b;
         3'b101:  r = a | ~b;
         3'b110:  r = a - b;
         3'b111:  r = ($signed(a) < $signed(b)) ? 4'd1 : 4'd0;
         default: begin r = 4'd0; e = 1'b1; end
      endcase
      return {e, r};
   endfunction

   // Scoreboard: pop on consumption first, then push whatever is accepted this cycle
   always @(negedge clk) begin
      logic [5:0] exp_e;
      if (rst_n) begin
         if (res_valid && res_ready) begin
            checks++;
            if (sb.size() == 0) begin
               failures++;
               $display("FAIL scoreboard_underflow got id=%0d err=%0d data=%h with nothing expected",
                        res_id, res_err, res_data);
            end else begin
               exp_e = sb.pop_front();
               if ({res_id, res_err, res_data} !== exp_e) begin
                  failures++;
                  $display("FAIL scoreboard got id=%0d err=%0d data=%h exp id=%0d err=%0d data=%h",
                           res_id, res_err, res_data, exp_e[5], exp_e[4], exp_e[3:0]);
               end
            end
         end
         if (req0_ready && req1_ready) begin
            checks++;
            failures++;
            $display("FAIL double_grant got req0_ready=1 req1_ready=1 exp at most one");
         end
         if (req0_valid && req0_ready) sb.push_back({1'b0, ref_alu(req0_a, req0_b, req0_op)});
         if (req1_valid && req1_ready) sb.push_back({1'b1, ref_alu(req1_a, req1_b, req1_op)});
      end
   end

   task automatic release_reset();
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      rst_n      = 1'b0;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      res_ready  = 1'b0;
      sb.delete();
      repeat (2) @(posedge clk);
      release_reset();
   endtask

   task automatic send(input logic id, input logic [3:0] a, input logic [3:0] b,
                       input logic [2:0] op);
      int   n;
      logic rdy;
      if (id) begin
         req1_a = a; req1_b = b; req1_op = op; req1_valid = 1'b1;
      end else begin
         req0_a = a; req0_b = b; req0_op = op; req0_valid = 1'b1;
      end
      @(negedge clk);
      rdy = id ? req1_ready : req0_ready;
      n = 0;
      while (!rdy && n < 20) begin
         @(negedge clk);
         rdy = id ? req1_ready : req0_ready;
         n++;
      end
      checks++;
      if (!rdy) begin
         failures++;
         $display("FAIL send_timeout id=%0d got ready=0 exp ready=1 within 20 cycles", id);
      end
      @(posedge clk);
      #1;
      if (id) req1_valid = 1'b0;
      else    req0_valid = 1'b0;
   endtask

   task automatic check_res(input string name, input logic v, input logic [3:0] d,
                            input logic id, input logic e);
      checks++;
      if ({res_valid, res_data, res_id, res_err} !== {v, d, id, e}) begin
         failures++;
         $display("FAIL %s got v=%0d data=%h id=%0d err=%0d exp v=%0d data=%h id=%0d err=%0d",
                  name, res_valid, res_data, res_id, res_err, v, d, id, e);
      end
   endtask

   task automatic check_ready(input string name, input logic r0, input logic r1);
      checks++;
      if ({req0_ready, req1_ready} !== {r0, r1}) begin
         failures++;
         $display("FAIL %s got ready0=%0d ready1=%0d exp ready0=%0d ready1=%0d",
                  name, req0_ready, req1_ready, r0, r1);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      req0_a = 4'd0; req0_b = 4'd0; req0_op = OP_AND;
      req1_a = 4'd0; req1_b = 4'd0; req1_op = OP_AND;
      req0_valid = 1'b1;
      req1_valid = 1'b1;
      res_ready  = 1'b1;
      #3;
      check_ready("reset_ready", 1'b0, 1'b0);
      check_res("reset_res", 1'b0, 4'd0, 1'b0, 1'b0);
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      release_reset();
      check_res("post_reset_res", 1'b0, 4'd0, 1'b0, 1'b0);
   endtask

   task automatic test_basic();
      res_ready = 1'b1;
      req0_a = 4'd3; req0_b = 4'd4; req0_op = OP_ADD; req0_valid = 1'b1;
      @(negedge clk);
      check_ready("basic_grant", 1'b1, 1'b0);
      @(posedge clk);
      #1;
      req0_valid = 1'b0;
      check_res("basic_result", 1'b1, 4'd7, 1'b0, 1'b0);
   endtask

   task automatic test_tie();
      apply_reset();
      res_ready = 1'b1;
      req0_a = 4'b1000; req0_b = 4'd1; req0_op = OP_SUB; req0_valid = 1'b1;
      req1_a = 4'd6;    req1_b = 4'd3; req1_op = OP_AND; req1_valid = 1'b1;
      @(negedge clk);
      check_ready("tie_first", 1'b1, 1'b0);
      @(posedge clk);
      #1;
      req0_valid = 1'b0;
      check_res("tie_res0", 1'b1, 4'b0111, 1'b0, 1'b0);
      @(negedge clk);
      check_ready("tie_second", 1'b0, 1'b1);
      @(posedge clk);
      #1;
      req1_valid = 1'b0;
      check_res("tie_res1", 1'b1, 4'b0010, 1'b1, 1'b0);
   endtask

   task automatic test_backpressure();
      res_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      res_ready = 1'b0;
      req0_a = 4'd1; req0_b = 4'd1; req0_op = OP_ADD; req0_valid = 1'b1;
      @(negedge clk);
      check_ready("bp_grant", 1'b1, 1'b0);
      @(posedge clk);
      #1;
      req0_valid = 1'b0;
      req1_a = 4'd2; req1_b = 4'd5; req1_op = OP_OR; req1_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check_ready("bp_stall_ready", 1'b0, 1'b0);
         check_res("bp_hold", 1'b1, 4'd2, 1'b0, 1'b0);
      end
      @(posedge clk);
      #1;
      res_ready = 1'b1;
      @(negedge clk);
      check_ready("bp_release_grant", 1'b0, 1'b1);
      @(posedge clk);
      #1;
      req1_valid = 1'b0;
      check_res("bp_no_bubble", 1'b1, 4'd7, 1'b1, 1'b0);
   endtask

   task automatic test_illegal();
      res_ready = 1'b1;
      send(1'b1, 4'd5, 4'd2, OP_ILL);
      check_res("illegal_op", 1'b1, 4'd0, 1'b1, 1'b1);
      send(1'b0, 4'd4, 4'd1, OP_SUB);
      check_res("illegal_cleared", 1'b1, 4'd3, 1'b0, 1'b0);
   endtask

   task automatic test_reset_mid();
      res_ready = 1'b1;
      send(1'b0, 4'd3, 4'd3, OP_AND);
      res_ready = 1'b0;
      check_res("rmid_pre", 1'b1, 4'd3, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      check_res("rmid_async_clear", 1'b0, 4'd0, 1'b0, 1'b0);
      sb.delete();
      @(negedge clk);
      release_reset();
      res_ready = 1'b1;
      req0_a = 4'd2; req0_b = 4'd2; req0_op = OP_ADD; req0_valid = 1'b1;
      req1_a = 4'd7; req1_b = 4'd1; req1_op = OP_SUB; req1_valid = 1'b1;
      @(negedge clk);
      check_ready("rmid_tie_first", 1'b1, 1'b0);
      @(posedge clk);
      #1;
      req0_valid = 1'b0;
      check_res("rmid_res0", 1'b1, 4'd4, 1'b0, 1'b0);
      @(negedge clk);
      check_ready("rmid_tie_second", 1'b0, 1'b1);
      @(posedge clk);
      #1;
      req1_valid = 1'b0;
      check_res("rmid_res1", 1'b1, 4'd6, 1'b1, 1'b0);
   endtask

   task automatic test_sweep();
      logic [2:0] ops[7];
      logic [3:0] av, bv, dv;
      int n;
      ops = '{OP_AND, OP_OR, OP_ADD, OP_ANDN, OP_ORN, OP_SUB, OP_SLT};
      n = 0;
      res_ready = 1'b1;
      for (int k = 0; k < 7; k++) begin
         for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
               av = a[3:0];
               bv = b[3:0];
               dv = av - bv;
               if (ops[k] == OP_SLT && av[3] != bv[3] && dv[3] != av[3]) continue;
               send(n[0], av, bv, ops[k]);
               n++;
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      res_ready = 1'b1;
      send(1'b1, 4'd1, 4'd1, OP_OR);
      req0_a = 4'd1; req0_b = 4'd2; req0_op = OP_ADD; req0_valid = 1'b1;
      req1_a = 4'd6; req1_b = 4'd1; req1_op = OP_SUB; req1_valid = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         check_ready("b2b_alternate", (i % 2) == 0, (i % 2) == 1);
         @(posedge clk);
         #1;
         check_res("b2b_result", 1'b1, ((i % 2) == 0) ? 4'd3 : 4'd5, (i % 2) == 1, 1'b0);
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
   endtask

   task automatic test_drain();
      res_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_res("drain_idle", 1'b0, 4'd5, 1'b1, 1'b0);
      checks++;
      if (sb.size() != 0) begin
         failures++;
         $display("FAIL drain_scoreboard got %0d pending exp 0", sb.size());
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_tie();
      test_backpressure();
      test_illegal();
      test_reset_mid();
      test_sweep();
      test_back_to_back();
      test_drain();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
